// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-Lite word-organised data memory slave.
//
// Serves one read and one write transaction at a time, each through its own
// independent FSM. Every transaction waits d extra cycles before responding,
// where d is either FIXED_DELAY or the low nibble of a free-running LFSR. The
// LFSR value is sampled when the transaction is accepted.
//
// Misaligned LSU accesses arrive as two ordinary word transactions. Data and
// strobes come in already lane-rotated, so addr[1:0] is ignored. Addresses
// outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) get DECERR: reads return
// zero and writes are dropped, with the same timing as in-range accesses.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   awvalid/awready/awaddr    write address channel
//   wvalid/wready/wdata/wstrb write data channel (pre-rotated data and strobes)
//   bvalid/bready/bresp       write response (00 OKAY, 11 DECERR)
//   arvalid/arready/araddr    read address channel
//   rvalid/rready/rresp/rdata read data channel (00 OKAY, 11 DECERR)
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an AR handshake
//   R_WAIT | counting down the response delay
//   R_RESP | rvalid high, rdata/rresp held until rready
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W, in either order
//   W_WAIT | counting down the response delay
//   W_RESP | bvalid high until bready
module axi_lite_sram #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter bit          RANDOM_DELAY = 1'b0,
   parameter int unsigned FIXED_DELAY  = 1,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   output logic        rvalid,
   input  logic        rready,
   output logic [1:0]  rresp,
   output logic [31:0] rdata
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   logic [31:0] mem_q [DEPTH_WORDS];

   // ---------------- delay source ----------------
   logic [7:0] lfsr_q;
   logic [3:0] dly;

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   // Both FSMs read the same dly, so simultaneous accepts see the same value.
   assign dly = RANDOM_DELAY ? lfsr_q[3:0] : 4'(FIXED_DELAY);

   // ---------------- read side ----------------
   r_state_t    r_state_q;
   logic [3:0]  r_cnt_q;
   logic [31:0] araddr_q;
   logic        arready_q, rvalid_q;
   logic [1:0]  rresp_q;
   logic [31:0] rdata_q;
   logic        ar_hs, r_sample, ar_in;
   logic [31:0] ar_addr_eff, ar_off;
   logic [IDX_W-1:0] ar_idx;

   assign ar_hs       = (r_state_q == R_IDLE) && arvalid && arready_q;
   // With zero delay, memory is sampled on the accept edge using the live address.
   assign ar_addr_eff = ar_hs ? araddr : araddr_q;
   assign ar_off      = ar_addr_eff - BASE_ADDR;
   assign ar_in       = {1'b0, ar_off} < SPAN;
   assign ar_idx      = ar_off[IDX_W+1:2];
   assign r_sample    = (ar_hs && (dly == 4'd0)) || ((r_state_q == R_WAIT) && (r_cnt_q == 4'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= 4'd0;
         araddr_q  <= 32'd0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= OKAY;
         rdata_q   <= 32'd0;
      end else begin
         if (r_sample) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_in ? OKAY : DECERR;
            rdata_q  <= ar_in ? mem_q[ar_idx] : 32'd0;
         end
         unique case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  araddr_q  <= araddr;
                  r_cnt_q   <= dly;
                  arready_q <= 1'b0;
                  r_state_q <= (dly == 4'd0) ? R_RESP : R_WAIT;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_WAIT: begin
               r_cnt_q <= r_cnt_q - 4'd1;
               if (r_cnt_q == 4'd1) r_state_q <= R_RESP;
            end
            R_RESP: begin
               if (rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= R_IDLE;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // ---------------- write side ----------------
   w_state_t    w_state_q;
   logic [3:0]  w_cnt_q;
   logic [31:0] awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_have_q, w_have_q;
   logic        awready_q, wready_q, bvalid_q;
   logic [1:0]  bresp_q;
   logic        aw_hs, w_hs, aw_got, w_got, w_start, w_commit, aw_in;
   logic [31:0] aw_addr_eff, aw_off, wdata_eff;
   logic [3:0]  wstrb_eff;
   logic [IDX_W-1:0] aw_idx;

   assign aw_hs       = (w_state_q == W_IDLE) && awvalid && awready_q;
   assign w_hs        = (w_state_q == W_IDLE) && wvalid && wready_q;
   assign aw_got      = aw_have_q | aw_hs;
   assign w_got       = w_have_q | w_hs;
   assign w_start     = (w_state_q == W_IDLE) && aw_got && w_got;
   assign w_commit    = (w_start && (dly == 4'd0)) || ((w_state_q == W_WAIT) && (w_cnt_q == 4'd1));
   assign aw_addr_eff = aw_hs ? awaddr : awaddr_q;
   assign wdata_eff   = w_hs ? wdata : wdata_q;
   assign wstrb_eff   = w_hs ? wstrb : wstrb_q;
   assign aw_off      = aw_addr_eff - BASE_ADDR;
   assign aw_in       = {1'b0, aw_off} < SPAN;
   assign aw_idx      = aw_off[IDX_W+1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_cnt_q   <= 4'd0;
         awaddr_q  <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
      end else begin
         if (w_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_in ? OKAY : DECERR;
         end
         unique case (w_state_q)
            W_IDLE: begin
               if (aw_hs) begin
                  awaddr_q  <= awaddr;
                  aw_have_q <= 1'b1;
               end
               if (w_hs) begin
                  wdata_q  <= wdata;
                  wstrb_q  <= wstrb;
                  w_have_q <= 1'b1;
               end
               if (w_start) begin
                  aw_have_q <= 1'b0;
                  w_have_q  <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  w_cnt_q   <= dly;
                  w_state_q <= (dly == 4'd0) ? W_RESP : W_WAIT;
               end else begin
                  awready_q <= !aw_got;
                  wready_q  <= !w_got;
               end
            end
            W_WAIT: begin
               w_cnt_q <= w_cnt_q - 4'd1;
               if (w_cnt_q == 4'd1) w_state_q <= W_RESP;
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Byte-masked commit; gated by rst so a reset edge never lands a pending write.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && aw_in) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_eff[b]) mem_q[aw_idx][8*b +: 8] <= wdata_eff[8*b +: 8];
         end
      end
   end

   // Offset bits outside the word index carry no information once range is known.
   logic unused_off;
   assign unused_off = ^{ar_off[31:IDX_W+2], ar_off[1:0], aw_off[31:IDX_W+2], aw_off[1:0]};

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_sram.sv
module tb_axi_lite_sram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;   // 0: fixed-delay instance, 1: random-delay instance
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;

   logic        a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
   logic [1:0]  a_bresp, a_rresp;
   logic [31:0] a_rdata;
   logic        b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
   logic [1:0]  b_bresp, b_rresp;
   logic [31:0] b_rdata;

   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   assign awready = sel ? b_awready : a_awready;
   assign wready  = sel ? b_wready  : a_wready;
   assign bvalid  = sel ? b_bvalid  : a_bvalid;
   assign bresp   = sel ? b_bresp   : a_bresp;
   assign arready = sel ? b_arready : a_arready;
   assign rvalid  = sel ? b_rvalid  : a_rvalid;
   assign rresp   = sel ? b_rresp   : a_rresp;
   assign rdata   = sel ? b_rdata   : a_rdata;

   axi_lite_sram #(
      .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .RANDOM_DELAY(1'b0),
      .FIXED_DELAY(1), .LFSR_SEED(8'hA5)
   ) u_fix (
      .clk(clk), .rst(rst),
      .awvalid(awvalid & ~sel), .awready(a_awready), .awaddr(awaddr),
      .wvalid(wvalid & ~sel), .wready(a_wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(a_bvalid), .bready(bready), .bresp(a_bresp),
      .arvalid(arvalid & ~sel), .arready(a_arready), .araddr(araddr),
      .rvalid(a_rvalid), .rready(rready), .rresp(a_rresp), .rdata(a_rdata)
   );

   axi_lite_sram #(
      .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .RANDOM_DELAY(1'b1),
      .FIXED_DELAY(1), .LFSR_SEED(8'hA5)
   ) u_rnd (
      .clk(clk), .rst(rst),
      .awvalid(awvalid & sel), .awready(b_awready), .awaddr(awaddr),
      .wvalid(wvalid & sel), .wready(b_wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(b_bvalid), .bready(bready), .bresp(b_bresp),
      .arvalid(arvalid & sel), .arready(b_arready), .araddr(araddr),
      .rvalid(b_rvalid), .rready(rready), .rresp(b_rresp), .rdata(b_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // lat = clock edges from the last address/data handshake edge to the first edge seeing bvalid.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
      logic aw_now, w_now;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 40 && (awvalid || wvalid); i++) begin
         aw_now = awvalid & awready;
         w_now  = wvalid & wready;
         tick();
         if (aw_now) awvalid = 1'b0;
         if (w_now)  wvalid  = 1'b0;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < 40) begin
         tick();
         lat++;
      end
      chk("wr_bvalid_seen", 32'(bvalid), 32'd1);
      resp = bresp;
      bready = 1'b1; tick(); bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 40 && !arready; i++) tick();
      tick();
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 40) begin
         tick();
         lat++;
      end
      chk("rd_rvalid_seen", 32'(rvalid), 32'd1);
      data = rdata; resp = rresp;
      rready = 1'b1; tick(); rready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data, hold;
      logic [31:0] model [16];
      int          lat, seen;
      logic        got;

      rst = 1'b1; sel = 1'b0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; wdata = 0; araddr = 0; wstrb = 0;
      repeat (3) tick();
      chk("rst_ctrl_outputs", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 32'({awready, wready, arready}), 32'd7);

      // fixed delay 1: full-word write then readback
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
      chk("w1_bresp", 32'(resp), 32'd0);
      chk("w1_latency", 32'(lat), 32'd2);
      do_read(32'h8000_0010, data, resp, lat);
      chk("r1_rdata", data, 32'hDEAD_BEEF);
      chk("r1_rresp", 32'(resp), 32'd0);
      chk("r1_latency", 32'(lat), 32'd2);

      // partial strobe, then strobe 0 leaves word unchanged
      do_write(32'h8000_0020, 32'h1122_3344, 4'hF, resp, lat);
      do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0110, resp, lat);
      chk("ps_bresp", 32'(resp), 32'd0);
      do_read(32'h8000_0020, data, resp, lat);
      chk("ps_rdata", data, 32'h11BB_CC44);
      do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, resp, lat);
      chk("strb0_bresp", 32'(resp), 32'd0);
      do_read(32'h8000_0023, data, resp, lat);
      chk("strb0_rdata", data, 32'h11BB_CC44);

      // AW three cycles ahead of W, bready held low for four cycles
      awaddr = 32'h8000_0040; awvalid = 1'b1;
      for (int i = 0; i < 10 && !awready; i++) tick();
      tick();
      awvalid = 1'b0;
      chk("early_aw_awready_low", 32'(awready), 32'd0);
      chk("early_aw_wready_high", 32'(wready), 32'd1);
      tick(); tick();
      wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("early_aw_b_not_yet", 32'(bvalid), 32'd0);
      tick();
      chk("early_aw_b_latency", 32'(bvalid), 32'd1);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bvalid && bresp == 2'b00) seen++;
      end
      chk("bvalid_held", 32'(seen), 32'd4);
      bready = 1'b1; tick(); bready = 1'b0;
      chk("bvalid_dropped", 32'(bvalid), 32'd0);
      chk("wr_ready_back", 32'({awready, wready}), 32'd3);
      tick();
      chk("single_bresp", 32'(bvalid), 32'd0);

      // rready held low for five cycles
      araddr = 32'h8000_0040; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 40) begin
         tick();
         lat++;
      end
      chk("rhold_latency", 32'(lat), 32'd2);
      hold = rdata;
      chk("rhold_rdata", hold, 32'hCAFE_F00D);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rvalid && rdata == hold && !arready) seen++;
      end
      chk("rvalid_rdata_stable", 32'(seen), 32'd5);
      rready = 1'b1; tick(); rready = 1'b0;
      chk("rvalid_dropped", 32'(rvalid), 32'd0);
      chk("arready_back", 32'(arready), 32'd1);

      // out of range
      do_write(32'h8000_0000, 32'h5A5A_0001, 4'hF, resp, lat);
      do_read(32'h7FFF_FFFC, data, resp, lat);
      chk("oor_rresp", 32'(resp), 32'd3);
      chk("oor_rdata", data, 32'd0);
      chk("oor_rlatency", 32'(lat), 32'd2);
      do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, resp, lat);
      chk("oor_bresp", 32'(resp), 32'd3);
      chk("oor_wlatency", 32'(lat), 32'd2);
      do_read(32'h8000_0000, data, resp, lat);
      chk("word0_intact", data, 32'h5A5A_0001);

      // read sample and write commit on the same edge: read sees old data
      do_write(32'h8000_0050, 32'h0101_0101, 4'hF, resp, lat);
      awaddr = 32'h8000_0050; wdata = 32'h0202_0202; wstrb = 4'hF; araddr = 32'h8000_0050;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 40 && !(rvalid && bvalid); i++) tick();
      chk("same_edge_both_valid", 32'({rvalid, bvalid}), 32'd3);
      chk("same_edge_old_data", rdata, 32'h0101_0101);
      rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
      do_read(32'h8000_0050, data, resp, lat);
      chk("same_edge_new_data", data, 32'h0202_0202);

      // random-delay instance: reset while the read FSM is waiting
      sel = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         araddr = 32'h8000_0000 + 32'(4 * k); arvalid = 1'b1;
         for (int i = 0; i < 40 && !arready; i++) tick();
         tick();
         arvalid = 1'b0;
         if (!rvalid) got = 1'b1;
         else begin
            rready = 1'b1; tick(); rready = 1'b0;
         end
      end
      chk("found_r_wait", 32'(got), 32'd1);
      rst = 1'b1;
      tick();
      chk("midrst_ctrl_outputs", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_ready_back", 32'({awready, wready, arready}), 32'd7);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (rvalid || bvalid) seen++;
         tick();
      end
      chk("midrst_no_response", 32'(seen), 32'd0);

      // scoreboard: initialise 16 words, then 200 random transactions
      for (int i = 0; i < 16; i++) begin
         model[i] = $urandom;
         do_write(32'h8000_0000 + 32'(4 * i), model[i], 4'hF, resp, lat);
         chk("init_bresp", 32'(resp), 32'd0);
      end
      for (int n = 0; n < 200; n++) begin
         int          k;
         logic        oor;
         logic [31:0] a, d;
         logic [3:0]  s;
         k   = $urandom_range(0, 15);
         oor = ($urandom_range(0, 7) == 0);
         if (oor) a = ($urandom_range(0, 1) == 1) ? 32'h8000_1000 + 32'(4 * k)
                                                  : 32'h7FFF_FFC0 + 32'(4 * k);
         else     a = 32'h8000_0000 + 32'(4 * k);
         a[1:0] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, resp, lat);
            chk("rnd_bresp", 32'(resp), oor ? 32'd3 : 32'd0);
            chk("rnd_wlat_max", 32'(lat <= 16), 32'd1);
            if (!oor) begin
               for (int b = 0; b < 4; b++) begin
                  if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
               end
            end
         end else begin
            do_read(a, data, resp, lat);
            chk("rnd_rdata", data, oor ? 32'd0 : model[k]);
            chk("rnd_rresp", 32'(resp), oor ? 32'd3 : 32'd0);
            chk("rnd_rlat_max", 32'(lat <= 16), 32'd1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
